// File: rtl/fp_mult_pkg.sv
// Shared types and width helpers for the pipelined floating-point multiplier.
// Operand layout is {sign, exponent, mantissa}. The width helpers take
// EXP_W/MAN_W as arguments so that every instance can use a different format.
package fp_mult_pkg;

   localparam int FP_MAX_W = 128;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_e;

   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

   // Stage header: the fields that do not depend on the format width. The
   // width-dependent fields (exponent, significand, tag) sit next to it in
   // each stage.
   typedef struct packed {
      logic      sign;
      fp_class_e cls;
   } fp_stage_hdr_t;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int fp_prod_w(input int man_w);
      return 2 * (man_w + 1);
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set.
   // The result is right-aligned in FP_MAX_W bits. Callers keep the low
   // fp_width() bits.
   function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
      logic [FP_MAX_W-1:0] q;
      q = '0;
      for (int i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
      q[man_w - 1] = 1'b1;
      return q;
   endfunction

endpackage

// File: rtl/fp_mult_pipe_round_pack.sv
// fp_round_pack: combinational back end of the multiplier.
// It takes a normalized significand product and does round-to-nearest-even,
// the exponent range check (overflow to Inf, flush-to-zero on underflow),
// packing of special classes, and flag generation.
// Ports:
//   sign, cls  result sign and class from unpack
//   exp_in     signed working exponent, already adjusted for normalization
//   prod       product with its leading one at the MSB
//   result     packed {sign, exp, man}
//   flags      invalid / overflow / underflow / inexact
module fp_round_pack
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   sign,
   input  fp_class_e              cls,
   input  logic signed [EXP_W+1:0] exp_in,
   input  logic [2*MAN_W+1:0]     prod,
   output logic [EXP_W+MAN_W:0]   result,
   output fp_flags_t              flags
);

   localparam int XW = EXP_W + 2;
   localparam logic [FP_MAX_W-1:0]  QNAN_FULL = fp_qnan(EXP_W, MAN_W);
   localparam logic [EXP_W+MAN_W:0] QNAN      = QNAN_FULL[EXP_W+MAN_W:0];
   localparam logic signed [XW-1:0] EXP_MAX   = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO  = '0;

   logic [MAN_W-1:0]        man;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;
   logic [MAN_W:0]          man_r;
   logic signed [XW-1:0]    exp_r;

   always_comb begin
      // Bit 2*MAN_W+1 is the hidden one and is not stored.
      man      = prod[2*MAN_W:MAN_W+1];
      guard    = prod[MAN_W];
      sticky   = |prod[MAN_W-1:0];
      round_up = guard & (sticky | man[0]);
      man_r    = {1'b0, man} + (MAN_W+1)'(round_up);
      // If rounding carries out, the stored mantissa is already all zeros.
      exp_r    = exp_in + XW'(man_r[MAN_W]);

      result = '0;
      flags  = '0;
      case (cls)
         NAN: begin
            result        = QNAN;
            flags.invalid = 1'b1;
         end
         INF: begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
         ZERO: begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
         end
         default: begin
            if (exp_r >= EXP_MAX) begin
               result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags.overflow = 1'b1;
               flags.inexact  = 1'b1;
            end else if (exp_r <= EXP_ZERO) begin
               result          = {sign, {(EXP_W+MAN_W){1'b0}}};
               flags.underflow = 1'b1;
               flags.inexact   = 1'b1;
            end else begin
               result        = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
               flags.inexact = guard | sticky;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: parametrised pipelined IEEE-754 multiplier with a
// valid/ready handshake. Its latency is MUL_STAGES+3 cycles. The stages are
// unpack, the significand multiply (MUL_STAGES registers), normalize, and
// round/pack. Subnormal inputs are treated as zero, and results that would
// be subnormal are flushed to zero.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready, a, b, in_tag           operand side
//   out_valid/out_ready, result, out_tag      result side
//   invalid, overflow, underflow, inexact     exception flags, qualified by out_valid
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W      = 8,
   parameter int MAN_W      = 23,
   parameter int MUL_STAGES = 1,
   parameter int TAG_W      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 invalid,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 inexact
);

   localparam int W    = fp_width(EXP_W, MAN_W);
   localparam int PW   = fp_prod_w(MAN_W);
   localparam int XW   = EXP_W + 2;
   localparam int LAST = MUL_STAGES - 1;
   localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));
   localparam logic signed [XW-1:0] ONE_X  = XW'(1);

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      if (e == '0) return ZERO;
      if (e == '1) return (m == '0) ? INF : NAN;
      return NORM;
   endfunction

   // Single global enable. A stalled result holds the whole pipe, so bubbles
   // stay in place and order is preserved.
   logic adv;
   assign adv      = !(out_valid & !out_ready);
   assign in_ready = adv;

   // Stage 1: unpack / classify
   fp_class_e            cls_a, cls_b;
   logic                 s1_valid_d, s1_valid_q;
   fp_stage_hdr_t        s1_hdr_d, s1_hdr_q;
   logic signed [XW-1:0] s1_exp_d, s1_exp_q;
   logic [MAN_W:0]       s1_sig_a_d, s1_sig_a_q, s1_sig_b_d, s1_sig_b_q;
   logic [TAG_W-1:0]     s1_tag_d, s1_tag_q;

   always_comb begin
      cls_a      = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
      cls_b      = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
      s1_valid_d = s1_valid_q;
      s1_hdr_d   = s1_hdr_q;
      s1_exp_d   = s1_exp_q;
      s1_sig_a_d = s1_sig_a_q;
      s1_sig_b_d = s1_sig_b_q;
      s1_tag_d   = s1_tag_q;
      if (adv) begin
         s1_valid_d    = in_valid;
         s1_tag_d      = in_tag;
         s1_hdr_d.sign = a[W-1] ^ b[W-1];
         if (cls_a == NAN || cls_b == NAN ||
             (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
            s1_hdr_d.cls = NAN;
         else if (cls_a == INF || cls_b == INF)
            s1_hdr_d.cls = INF;
         else if (cls_a == ZERO || cls_b == ZERO)
            s1_hdr_d.cls = ZERO;
         else
            s1_hdr_d.cls = NORM;
         s1_exp_d   = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS_X;
         s1_sig_a_d = {1'b1, a[MAN_W-1:0]};
         s1_sig_b_d = {1'b1, b[MAN_W-1:0]};
      end
   end

   // Multiply stages. The product is formed ahead of the first register.
   // The remaining registers give retiming room for deeper configurations.
   logic                 m_valid_d [MUL_STAGES], m_valid_q [MUL_STAGES];
   fp_stage_hdr_t        m_hdr_d   [MUL_STAGES], m_hdr_q   [MUL_STAGES];
   logic signed [XW-1:0] m_exp_d   [MUL_STAGES], m_exp_q   [MUL_STAGES];
   logic [PW-1:0]        m_prod_d  [MUL_STAGES], m_prod_q  [MUL_STAGES];
   logic [TAG_W-1:0]     m_tag_d   [MUL_STAGES], m_tag_q   [MUL_STAGES];

   always_comb begin
      for (int k = 0; k < MUL_STAGES; k++) begin
         m_valid_d[k] = m_valid_q[k];
         m_hdr_d[k]   = m_hdr_q[k];
         m_exp_d[k]   = m_exp_q[k];
         m_prod_d[k]  = m_prod_q[k];
         m_tag_d[k]   = m_tag_q[k];
      end
      if (adv) begin
         m_valid_d[0] = s1_valid_q;
         m_hdr_d[0]   = s1_hdr_q;
         m_exp_d[0]   = s1_exp_q;
         m_prod_d[0]  = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
         m_tag_d[0]   = s1_tag_q;
         for (int k = 1; k < MUL_STAGES; k++) begin
            m_valid_d[k] = m_valid_q[k-1];
            m_hdr_d[k]   = m_hdr_q[k-1];
            m_exp_d[k]   = m_exp_q[k-1];
            m_prod_d[k]  = m_prod_q[k-1];
            m_tag_d[k]   = m_tag_q[k-1];
         end
      end
   end

   // Normalize: line the leading one up with the MSB.
   logic                 n_valid_d, n_valid_q;
   fp_stage_hdr_t        n_hdr_d, n_hdr_q;
   logic signed [XW-1:0] n_exp_d, n_exp_q;
   logic [PW-1:0]        n_prod_d, n_prod_q;
   logic [TAG_W-1:0]     n_tag_d, n_tag_q;

   always_comb begin
      n_valid_d = n_valid_q;
      n_hdr_d   = n_hdr_q;
      n_exp_d   = n_exp_q;
      n_prod_d  = n_prod_q;
      n_tag_d   = n_tag_q;
      if (adv) begin
         n_valid_d = m_valid_q[LAST];
         n_hdr_d   = m_hdr_q[LAST];
         n_tag_d   = m_tag_q[LAST];
         if (m_prod_q[LAST][PW-1]) begin
            n_prod_d = m_prod_q[LAST];
            n_exp_d  = m_exp_q[LAST] + ONE_X;
         end else begin
            n_prod_d = m_prod_q[LAST] << 1;
            n_exp_d  = m_exp_q[LAST];
         end
      end
   end

   // Round/pack feeds the output register.
   logic [W-1:0] rp_result;
   fp_flags_t    rp_flags;

   fp_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round_pack (
      .sign   (n_hdr_q.sign),
      .cls    (n_hdr_q.cls),
      .exp_in (n_exp_q),
      .prod   (n_prod_q),
      .result (rp_result),
      .flags  (rp_flags)
   );

   logic             out_valid_d, out_valid_q;
   logic [W-1:0]     out_result_d, out_result_q;
   fp_flags_t        out_flags_d, out_flags_q;
   logic [TAG_W-1:0] out_tag_d, out_tag_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_flags_d  = out_flags_q;
      out_tag_d    = out_tag_q;
      if (adv) begin
         out_valid_d  = n_valid_q;
         out_result_d = rp_result;
         out_flags_d  = rp_flags;
         out_tag_d    = n_tag_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q   <= 1'b0;
         s1_hdr_q     <= '0;
         s1_exp_q     <= '0;
         s1_sig_a_q   <= '0;
         s1_sig_b_q   <= '0;
         s1_tag_q     <= '0;
         for (int k = 0; k < MUL_STAGES; k++) begin
            m_valid_q[k] <= 1'b0;
            m_hdr_q[k]   <= '0;
            m_exp_q[k]   <= '0;
            m_prod_q[k]  <= '0;
            m_tag_q[k]   <= '0;
         end
         n_valid_q    <= 1'b0;
         n_hdr_q      <= '0;
         n_exp_q      <= '0;
         n_prod_q     <= '0;
         n_tag_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
         out_tag_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_hdr_q     <= s1_hdr_d;
         s1_exp_q     <= s1_exp_d;
         s1_sig_a_q   <= s1_sig_a_d;
         s1_sig_b_q   <= s1_sig_b_d;
         s1_tag_q     <= s1_tag_d;
         for (int k = 0; k < MUL_STAGES; k++) begin
            m_valid_q[k] <= m_valid_d[k];
            m_hdr_q[k]   <= m_hdr_d[k];
            m_exp_q[k]   <= m_exp_d[k];
            m_prod_q[k]  <= m_prod_d[k];
            m_tag_q[k]   <= m_tag_d[k];
         end
         n_valid_q    <= n_valid_d;
         n_hdr_q      <= n_hdr_d;
         n_exp_q      <= n_exp_d;
         n_prod_q     <= n_prod_d;
         n_tag_q      <= n_tag_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_flags_q  <= out_flags_d;
         out_tag_q    <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = out_result_q;
   assign out_tag   = out_tag_q;
   assign invalid   = out_flags_q.invalid;
   assign overflow  = out_flags_q.overflow;
   assign underflow = out_flags_q.underflow;
   assign inexact   = out_flags_q.inexact;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Testbench for fp_mult_pipe. It drives a single-precision instance
// (MUL_STAGES=1) and a double-precision instance (MUL_STAGES=3).
// Expected single-precision results come from an integer-arithmetic
// reference model with exact product, explicit remainder and tie-to-even.
module tb_fp_mult_pipe;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // single precision instance
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [3:0]  in_tag, out_tag;
   logic        invalid, overflow, underflow, inexact;
   logic [3:0]  flags;
   assign flags = {invalid, overflow, underflow, inexact};

   fp_mult_pipe dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
      .invalid(invalid), .overflow(overflow), .underflow(underflow), .inexact(inexact)
   );

   // double precision instance
   logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [63:0] d_a, d_b, d_result;
   logic [3:0]  d_in_tag, d_out_tag;
   logic        d_invalid, d_overflow, d_underflow, d_inexact;

   fp_mult_pipe #(.EXP_W(11), .MAN_W(52), .MUL_STAGES(3), .TAG_W(4)) dut_d (
      .clk(clk), .reset(reset),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b), .in_tag(d_in_tag),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result), .out_tag(d_out_tag),
      .invalid(d_invalid), .overflow(d_overflow), .underflow(d_underflow), .inexact(d_inexact)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Returns {invalid, overflow, underflow, inexact, result[31:0]}
   function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e, msb, sh;
      logic s, xz, yz, xi, yi, xn, yn, inx;
      longint unsigned p, kept, rem, half;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xz = (ex == 0);   yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 0);  yi = (ey == 255) && (y[22:0] == 0);
      xn = (ex == 255) && (x[22:0] != 0);  yn = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC00000};
      if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
      if (xz || yz) return {4'b0000, s, 31'h0};
      p    = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      msb  = (p >= (64'd1 << 47)) ? 47 : 46;
      sh   = msb - 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      e = ex + ey - 127 + (msb - 46);
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e    = e + 1;
      end
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
      if (e <= 0)   return {4'b0011, s, 31'h0};
      return {3'b000, inx, s, 8'(e), kept[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      int unsigned sel;
      logic [31:0] v;
      sel = $urandom_range(0, 99);
      v   = $urandom;
      if (sel < 65)      v[30:23] = 8'($urandom_range(90, 164));
      else if (sel < 82) v[30:23] = 8'($urandom_range(1, 254));
      else if (sel < 88) v[30:23] = 8'd0;
      else if (sel < 93) begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      else if (sel < 96) v[30:23] = 8'hFF;
      else               v[22:0]  = 23'($urandom_range(0, 3));
      return v;
   endfunction

   // Issues one op with out_ready=1 and measures handshake-to-result latency.
   task automatic run_single(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] xt,
                             output logic [31:0] r, output logic [3:0] f, output logic [3:0] t,
                             output int lat);
      r = 'x; f = 'x; t = 'x; lat = -1;
      out_ready = 1'b1;
      @(negedge clk);
      a = xa; b = xb; in_tag = xt; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i; r = result; f = flags; t = out_tag;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; in_tag = '0; out_ready = 1'b1;
      d_in_valid = 1'b0; d_a = '0; d_b = '0; d_in_tag = '0; d_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_assert++;
      if ({out_valid, result, out_tag, flags} !== 41'h0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", {out_valid, result, out_tag, flags});
      end
      n_assert++;
      if ({d_out_valid, d_result, d_out_tag, d_invalid, d_overflow, d_underflow, d_inexact} !== 73'h0) begin
         n_fail++; $display("FAIL reset_outputs_dp: got %h want 0", {d_out_valid, d_result});
      end
      reset = 1'b1;
      @(negedge clk);
      n_assert++;
      if ({in_ready, out_valid, d_in_ready, d_out_valid} !== 4'b1010) begin
         n_fail++; $display("FAIL reset_release_ready: got %b want 1010", {in_ready, out_valid, d_in_ready, d_out_valid});
      end
   endtask

   task automatic test_latency();
      logic [31:0] r; logic [3:0] f, t; int lat;
      run_single(32'h3FC00000, 32'h40000000, 4'hA, r, f, t, lat);
      n_assert++;
      if (lat != 4) begin n_fail++; $display("FAIL latency: got %0d want 4", lat); end
      n_assert++;
      if ({r, f, t} !== {32'h40400000, 4'h0, 4'hA}) begin
         n_fail++; $display("FAIL basic_mul: got %h/%b/%h want 40400000/0000/a", r, f, t);
      end
   endtask

   task automatic test_specials();
      logic [31:0] ta [11], tb [11], tr [11];
      logic [3:0]  tf [11];
      logic [31:0] r; logic [3:0] f, t; int lat;
      ta = '{32'h3F800001, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'hFF800000,
             32'h7FA00000, 32'h80000000, 32'h007FFFFF, 32'h7F800000, 32'h3F800000};
      tb = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000,
             32'h3F800000, 32'h40400000, 32'h40000000, 32'hFF800000, 32'h3F800000};
      tr = '{32'h3FC00002, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
             32'h7FC00000, 32'h80000000, 32'h00000000, 32'hFF800000, 32'h3F800000};
      tf = '{4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b1000, 4'b0000,
             4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 11; i++) begin
         run_single(ta[i], tb[i], 4'(i), r, f, t, lat);
         n_assert++;
         if ({lat == 4, r, f, t} !== {1'b1, tr[i], tf[i], 4'(i)}) begin
            n_fail++;
            $display("FAIL special_%0d: got %h/%b/%h lat %0d want %h/%b/%h lat 4",
                     i, r, f, t, lat, tr[i], tf[i], 4'(i));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] opa [8], opb [8];
      logic [39:0] expv [8];
      int nxt, got;
      logic acc, stalled, want_rdy;
      logic [40:0] snap;
      nxt = 0; got = 0; stalled = 1'b0; snap = '0;
      for (int i = 0; i < 8; i++) begin
         opa[i]  = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
         opb[i]  = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
         expv[i] = {4'(i + 8), ref_mul(opa[i], opb[i])};
      end
      @(posedge clk); #1;
      for (int c = 0; c < 26; c++) begin
         out_ready = !(c >= 5 && c <= 7);
         if (!in_valid && nxt < 8) begin
            a = opa[nxt]; b = opb[nxt]; in_tag = 4'(nxt + 8); in_valid = 1'b1;
         end
         @(negedge clk);
         want_rdy = !(c >= 5 && c <= 7);
         n_assert++;
         if (in_ready !== want_rdy) begin
            n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b want %b", c, in_ready, want_rdy);
         end
         if (stalled) begin
            n_assert++;
            if ({out_valid, result, out_tag, flags} !== snap) begin
               n_fail++; $display("FAIL bp_stable cycle %0d: got %h want %h", c, {out_valid, result, out_tag, flags}, snap);
            end
         end
         stalled = out_valid && !out_ready;
         snap    = {out_valid, result, out_tag, flags};
         if (out_valid && out_ready) begin
            n_assert++;
            if (got >= 8) begin
               n_fail++; $display("FAIL bp_extra_result: got %h want none", result);
            end else if ({out_tag, flags, result} !== expv[got]) begin
               n_fail++; $display("FAIL bp_result_%0d: got %h want %h", got, {out_tag, flags, result}, expv[got]);
            end
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin nxt++; in_valid = 1'b0; end
      end
      n_assert++;
      if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
      out_ready = 1'b1;
      in_valid  = 1'b0;
   endtask

   task automatic test_random();
      logic [39:0] exp_q [$];
      int issued, got;
      exp_q.delete();
      issued = 0; got = 0;
      @(posedge clk); #1;
      fork
         begin : driver
            logic acc;
            int cyc;
            cyc = 0;
            in_valid = 1'b0;
            while (issued < 300 && cyc < 5000) begin
               if (!in_valid && $urandom_range(0, 4) != 0) begin
                  a = rand_op(); b = rand_op(); in_tag = 4'($urandom); in_valid = 1'b1;
               end
               out_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               acc = in_valid && in_ready;
               @(posedge clk); #1;
               cyc++;
               if (acc) begin
                  exp_q.push_back({in_tag, ref_mul(a, b)});
                  issued++;
                  in_valid = 1'b0;
               end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         begin : monitor
            logic [39:0] e;
            logic stalled, want_rdy;
            logic [40:0] snap;
            int cyc;
            cyc = 0; stalled = 1'b0; snap = '0;
            while (got < 300 && cyc < 6000) begin
               @(negedge clk);
               cyc++;
               want_rdy = !(out_valid && !out_ready);
               n_assert++;
               if (in_ready !== want_rdy) begin
                  n_fail++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, want_rdy);
               end
               if (stalled) begin
                  n_assert++;
                  if ({out_valid, result, out_tag, flags} !== snap) begin
                     n_fail++; $display("FAIL rnd_stable: got %h want %h", {out_valid, result, out_tag, flags}, snap);
                  end
               end
               stalled = out_valid && !out_ready;
               snap    = {out_valid, result, out_tag, flags};
               if (out_valid && out_ready) begin
                  n_assert++;
                  if (exp_q.size() == 0) begin
                     n_fail++; $display("FAIL rnd_unexpected: got %h want nothing", {out_tag, flags, result});
                  end else begin
                     e = exp_q.pop_front();
                     if ({out_tag, flags, result} !== e) begin
                        n_fail++; $display("FAIL rnd_result_%0d: got %h want %h", got, {out_tag, flags, result}, e);
                     end
                  end
                  got++;
               end
            end
         end
      join
      n_assert++;
      if (got != 300 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL rnd_count: got %0d results (%0d pending) want 300", got, exp_q.size());
      end
   endtask

   task automatic test_reset_inflight();
      logic [31:0] r; logic [3:0] f, t; int lat;
      logic stale;
      out_ready = 1'b1;
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h3FC00000; b = 32'h40000000; in_tag = 4'(i + 1); in_valid = 1'b1;
         d_a = 64'h3FF8000000000000; d_b = 64'h4000000000000000; d_in_tag = 4'(i); d_in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      d_in_valid = 1'b0;
      @(posedge clk); #1;
      n_assert++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
      #2 reset = 1'b0;
      #1;
      n_assert++;
      if ({out_valid, result, out_tag, flags, d_out_valid} !== 42'h0) begin
         n_fail++; $display("FAIL rst_async_clear: got %h want 0", {out_valid, result, out_tag, flags, d_out_valid});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      stale = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid || d_out_valid) stale = 1'b1;
      end
      n_assert++;
      if (stale !== 1'b0) begin n_fail++; $display("FAIL rst_stale_result: got %b want 0", stale); end
      run_single(32'h3FC00000, 32'h40000000, 4'h7, r, f, t, lat);
      n_assert++;
      if ({lat == 4, r, f, t} !== {1'b1, 32'h40400000, 4'h0, 4'h7}) begin
         n_fail++; $display("FAIL rst_next_op: got %h/%b/%h lat %0d want 40400000/0000/7 lat 4", r, f, t, lat);
      end
   endtask

   task automatic test_double();
      logic [63:0] r; logic [3:0] f, t; int lat;
      r = 'x; f = 'x; t = 'x; lat = -1;
      d_out_ready = 1'b1;
      @(negedge clk);
      d_a = 64'h3FF8000000000000; d_b = 64'h4000000000000000; d_in_tag = 4'h5; d_in_valid = 1'b1;
      @(posedge clk);
      #1 d_in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (d_out_valid) begin
            lat = i; r = d_result; f = {d_invalid, d_overflow, d_underflow, d_inexact}; t = d_out_tag;
            break;
         end
      end
      n_assert++;
      if (lat != 6) begin n_fail++; $display("FAIL dp_latency: got %0d want 6", lat); end
      n_assert++;
      if ({r, f, t} !== {64'h4008000000000000, 4'h0, 4'h5}) begin
         n_fail++; $display("FAIL dp_result: got %h/%b/%h want 4008000000000000/0000/5", r, f, t);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_specials();
      test_backpressure();
      test_random();
      repeat (8) @(posedge clk);
      test_reset_inflight();
      test_double();
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised pipelined IEEE-754 binary floating-point multiplier, the successor to the fixed 3-stage single-precision multiplier.
- Generic exponent and mantissa widths.
- Configurable multiply depth.
- Valid/ready handshake with backpressure.
- Round-to-nearest-even; correct NaN/Inf/zero handling; full exception flags.
- Sits between the operand-issue stage and the result writeback of the datapath experiments.

Parameters:
EXP_W, 8, exponent field width (≥3)
MAN_W, 23, stored mantissa field width (≥2)
MUL_STAGES, 1, register stages in significand multiply (1..4)
TAG_W, 4, width of opaque tag carried with each operation

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  block accepts operands this cycle
a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
b  in  1+EXP_W+MAN_W  operand B
in_tag  in  TAG_W  tag, returned unchanged with result
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
result  out  1+EXP_W+MAN_W  product
out_tag  out  TAG_W  tag of this result
invalid  out  1  Inf×0 or NaN operand
overflow  out  1  result rounded to ±Inf
underflow  out  1  tiny nonzero result flushed to ±0
inexact  out  1  result differs from exact product

Behaviour:
- One clock. Reset is asynchronous and active-low.
- While reset=0:
  - All stage valid bits clear; in-flight operations are discarded.
  - out_valid=0; result, out_tag and all flags are 0.
  - in_ready=1 after release.
- Pipeline, L = MUL_STAGES+3 cycles from handshake (in_valid&in_ready) to out_valid:
  - S1: unpack; classify zero/inf/NaN; sign xor; exponent sum.
  - S2..S(1+MUL_STAGES): (MAN_W+1)×(MAN_W+1) significand multiply.
  - Normalize stage.
  - Round/pack stage; drives outputs.
- Flow control:
  - Global stall when out_valid & !out_ready; every stage holds.
  - in_ready = !(out_valid & !out_ready), combinational.
  - Bubbles do not collapse.
  - Results leave in issue order. No loss, no duplication.
  - Outputs stay stable while stalled.
- Input classes:
  - Subnormal inputs (exp=0) are treated as zero (DAZ).
  - exp all-ones with man≠0 is NaN.
  - exp all-ones with man=0 is ±Inf.
- Special results:
  - Any NaN operand → canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Inf×0 → canonical qNaN, invalid=1.
  - Inf×finite-nonzero or Inf×Inf → ±Inf, no flags.
  - Zero×finite → ±0, no flags.
- Arithmetic:
  - BIAS = 2^(EXP_W-1)-1.
  - Working exponent is signed, EXP_W+2 bits: e = ea+eb-BIAS.
  - If product bit 2·MAN_W+1 is set: shift right 1 and e+1.
- Rounding:
  - Guard = bit below LSB; sticky = OR of the rest.
  - Round up when guard & (sticky | LSB).
  - Mantissa carry-out renormalizes: mantissa=0, e+1.
  - inexact = guard|sticky.
- Range after rounding:
  - e ≥ 2^EXP_W-1 → ±Inf, overflow=1, inexact=1.
  - e ≤ 0 → ±0, underflow=1, inexact=1. Flush-to-zero; no subnormal outputs.
- Flags are valid only with out_valid. They are 0 for NaN-free exact normal results.
- Simultaneous input accept and output drain in one cycle is allowed: full throughput, 1 op/cycle.

Decomposition:
- Package fp_mult_pkg:
  - bias and field-width localparam functions of EXP_W/MAN_W.
  - Canonical qNaN constant builder.
  - fp_class_e enum {ZERO, NORM, INF, NAN}.
  - fp_flags_t struct {invalid, overflow, underflow, inexact}.
  - Per-stage payload struct (sign, class, exp, significand, tag).
- One sub-module: fp_round_pack. Combinational guard/sticky/RNE, exponent range check, special-case pack, flag generation. Instantiated before the final register stage.

Test Plan:
- Defaults, MUL_STAGES=1, out_ready=1: a=0x3FC00000, b=0x40000000 → result 0x40400000 exactly 4 cycles later, flags 0, out_tag echoes in_tag.
- Tie to even: a=0x3F800001, b=0x3FC00000 → 0x3FC00002, inexact=1. Separately, 0x3F800001×0x3F800001 → 0x3F800002, inexact=1.
- Overflow/underflow: 0x7F000000×0x7F000000 → 0x7F800000 with overflow=1, inexact=1. 0x00800000×0x00800000 → 0x00000000 with underflow=1, inexact=1.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000×0x40000000 → 0xFF800000, no flags.
  - 0x7FA00000×0x3F800000 → 0x7FC00000, invalid=1.
- Backpressure: issue 8 ops back-to-back with out_ready low for cycles 5–7 → in_ready low exactly during the stall, outputs stable, all 8 results in order with matching tags.
- Reset: assert reset low while 3 ops are in flight → out_valid=0 immediately (async). No stale result after release; next op completes with latency 4. Repeat with EXP_W=11, MAN_W=52, MUL_STAGES=3: 1.5×2.0 → 0x4008000000000000 after 6 cycles.
